// File: rtl/frv_dmem_responder.sv
// frv_dmem_responder: target end of the core dmem port. Requests are granted
// while the in-order response queue has room. Stores are applied to a
// word-addressed byte-lane SRAM. Loads and errors come back through the queue
// once the head entry has aged to the configured latency.
module frv_dmem_responder #(
  parameter logic [31:0] MEM_BASE  = 32'h0002_0000,
  parameter logic [31:0] MEM_MASK  = 32'hFFFF_F000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 1,
  parameter int          QDEPTH    = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int         IDX_W   = $clog2(MEM_WORDS);
  localparam int         PTR_W   = $clog2(QDEPTH);
  localparam int         CNT_W   = $clog2(QDEPTH + 1);
  localparam logic [2:0] AGE_MAX = 3'd7;
  localparam logic [3:0] LAT4    = 4'(LATENCY);

  // Response queue state: one slot per outstanding accepted request.
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [QDEPTH-1:0] valid_reg;
  logic [QDEPTH-1:0] error_reg;
  logic [2:0]        age_reg   [QDEPTH];
  logic [31:0]       rdata_reg [QDEPTH];

  // A load's SRAM word arrives one cycle after accept; it is written into its
  // slot then, and bypassed to the output while that write is pending.
  logic              fill_pend_reg;
  logic [PTR_W-1:0]  fill_ptr_reg;

  logic              addr_hit;
  logic [IDX_W-1:0]  word_idx;
  logic              push, pop, mem_wr, mem_rd, head_ready;
  logic [31:0]       mem_rdata;
  logic [31:0]       head_rdata;

  assign addr_hit = (dmem_addr & MEM_MASK) == MEM_BASE;
  assign word_idx = dmem_addr[IDX_W+1:2];

  // Grant depends only on the registered count, so a pop never frees a slot
  // for the same cycle. Holding gnt low in reset also blocks any SRAM write.
  assign dmem_gnt = g_resetn && (count_reg < CNT_W'(QDEPTH));
  assign push     = dmem_req && dmem_gnt;
  assign mem_wr   = push && addr_hit && dmem_wen;
  assign mem_rd   = push && addr_hit && !dmem_wen;

  // Head is ready once it has been queued for LATENCY-1 cycles.
  assign head_ready = (count_reg != '0) &&
                      ((4'(age_reg[head_reg]) + 4'd1) >= LAT4);
  assign dmem_recv  = g_resetn && head_ready;
  assign pop        = dmem_recv && dmem_ack;

  assign head_rdata = (fill_pend_reg && (fill_ptr_reg == head_reg)) ?
                      mem_rdata : rdata_reg[head_reg];
  assign dmem_rdata = dmem_recv ? head_rdata : 32'd0;
  assign dmem_error = dmem_recv && error_reg[head_reg];

  // SRAM split into four byte lanes so each strobe gates its own write port.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_WORDS];
    logic [7:0] lane_rdata_reg;

    // Strobed byte write and registered read of the indexed word.
    always_ff @(posedge g_clk) begin
      if (mem_wr && dmem_strb[gi]) begin
        lane_mem[word_idx] <= dmem_wdata[8*gi +: 8];
      end
      if (mem_rd) begin
        lane_rdata_reg <= lane_mem[word_idx];
      end
    end

    assign mem_rdata[8*gi +: 8] = lane_rdata_reg;
  end

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Queue pointers, per-slot ageing, entry capture and deferred load fill.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count_reg     <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      valid_reg     <= '0;
      error_reg     <= '0;
      fill_pend_reg <= 1'b0;
      fill_ptr_reg  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        age_reg[i]   <= 3'd0;
        rdata_reg[i] <= 32'd0;
      end
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < QDEPTH; i++) begin
        if (valid_reg[i] && (age_reg[i] != AGE_MAX)) begin
          age_reg[i] <= age_reg[i] + 3'd1;
        end
      end
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        age_reg[tail_reg]   <= 3'd0;
        error_reg[tail_reg] <= !addr_hit;
        rdata_reg[tail_reg] <= 32'd0;
        tail_reg            <= tail_reg + 1'b1;
      end
      if (fill_pend_reg) begin
        rdata_reg[fill_ptr_reg] <= mem_rdata;
      end
      fill_pend_reg <= mem_rd;
      fill_ptr_reg  <= tail_reg;
    end
  end

endmodule

// File: tb/tb_frv_dmem_responder.sv
// tb_frv_dmem_responder: directed bench for frv_dmem_responder. Instance A uses
// LATENCY=1, instance B uses LATENCY=3; both have QDEPTH=2.
module tb_frv_dmem_responder;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        a_req, a_wen, a_gnt, a_recv, a_ack, a_error;
  logic [3:0]  a_strb;
  logic [31:0] a_wdata, a_addr, a_rdata;
  logic        b_req, b_wen, b_gnt, b_recv, b_ack, b_error;
  logic [3:0]  b_strb;
  logic [31:0] b_wdata, b_addr, b_rdata;

  int n_pass  = 0;
  int n_total = 0;

  frv_dmem_responder #(.LATENCY(1), .QDEPTH(2)) u_dut_a (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .dmem_req(a_req), .dmem_wen(a_wen), .dmem_strb(a_strb),
    .dmem_wdata(a_wdata), .dmem_addr(a_addr), .dmem_gnt(a_gnt),
    .dmem_recv(a_recv), .dmem_ack(a_ack), .dmem_error(a_error),
    .dmem_rdata(a_rdata)
  );

  frv_dmem_responder #(.LATENCY(3), .QDEPTH(2)) u_dut_b (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .dmem_req(b_req), .dmem_wen(b_wen), .dmem_strb(b_strb),
    .dmem_wdata(b_wdata), .dmem_addr(b_addr), .dmem_gnt(b_gnt),
    .dmem_recv(b_recv), .dmem_ack(b_ack), .dmem_error(b_error),
    .dmem_rdata(b_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One request on A with ack high: gnt in the issue cycle, response next cycle.
  task automatic a_xact(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic exp_err);
    a_req = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wdata; a_strb = strb;
    @(negedge g_clk);
    check({tag, "_gnt"}, 32'(a_gnt), 32'd1);
    @(posedge g_clk); #1;
    a_req = 1'b0;
    @(negedge g_clk);
    check({tag, "_recv"}, 32'(a_recv), 32'd1);
    check({tag, "_rdata"}, a_rdata, exp_rdata);
    check({tag, "_err"}, 32'(a_error), 32'(exp_err));
    $display("xact %s wen=%0b addr=%08h rdata=%08h err=%0b", tag, wen, addr, a_rdata, a_error);
    @(posedge g_clk); #1;
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] pair_data [10];
  int          max_out;
  int          pops;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_req = 0; a_wen = 0; a_strb = 0; a_wdata = 0; a_addr = 0; a_ack = 1;
    b_req = 0; b_wen = 0; b_strb = 0; b_wdata = 0; b_addr = 0; b_ack = 0;

    // Reset state
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    check("rst_gnt_a", 32'(a_gnt), 32'd0);
    check("rst_gnt_b", 32'(b_gnt), 32'd0);
    check("rst_recv", 32'(a_recv), 32'd0);
    check("rst_err", 32'(a_error), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("post_rst_gnt", 32'(a_gnt), 32'd1);
    @(posedge g_clk); #1;

    // Store then load, LATENCY=1
    a_xact("t1_st", 1'b1, 32'h0002_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    a_xact("t1_ld", 1'b0, 32'h0002_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte strobes
    a_xact("t2_pre", 1'b1, 32'h0002_0020, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
    a_xact("t2_st", 1'b1, 32'h0002_0020, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
    a_xact("t2_ld", 1'b0, 32'h0002_0020, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);

    // Out-of-window accesses error and leave the aliased word untouched
    a_xact("t3_pre", 1'b1, 32'h0002_0000, 32'h0123_4567, 4'hF, 32'd0, 1'b0);
    a_xact("t3_ld0", 1'b0, 32'h0002_0000, 32'd0, 4'h0, 32'h0123_4567, 1'b0);
    a_xact("t3_miss_ld", 1'b0, 32'h0000_1000, 32'd0, 4'h0, 32'd0, 1'b1);
    a_xact("t3_miss_st", 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
    a_xact("t3_ld1", 1'b0, 32'h0002_0000, 32'd0, 4'h0, 32'h0123_4567, 1'b0);

    // Backpressure on B (LATENCY=3): preload three words
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      b_req = 1; b_wen = 1; b_strb = 4'hF; b_ack = 1;
      b_addr = 32'h0002_0040 + 32'(4 * k);
      b_wdata = 32'hB000_0000 + 32'(k);
      @(negedge g_clk);
      @(posedge g_clk); #1;
      b_req = 0;
      do begin @(negedge g_clk); w++; end while (!b_recv && w < 10);
      check("t4_pre_recv", 32'(b_recv), 32'd1);
      @(posedge g_clk); #1;
    end
    b_ack = 0; b_req = 1; b_wen = 0; b_addr = 32'h0002_0040;
    @(negedge g_clk);
    check("t4_gnt0", 32'(b_gnt), 32'd1);
    @(posedge g_clk); #1;
    b_addr = 32'h0002_0044;
    @(negedge g_clk);
    check("t4_gnt1", 32'(b_gnt), 32'd1);
    @(posedge g_clk); #1;
    b_addr = 32'h0002_0048;
    @(negedge g_clk);
    check("t4_full_gnt", 32'(b_gnt), 32'd0);
    check("t4_recv_early", 32'(b_recv), 32'd0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    check("t4_recv", 32'(b_recv), 32'd1);
    check("t4_rd0", b_rdata, 32'hB000_0000);
    check("t4_err0", 32'(b_error), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge g_clk); #1;
      @(negedge g_clk);
      check("t4_hold_recv", 32'(b_recv), 32'd1);
      check("t4_hold_rd", b_rdata, 32'hB000_0000);
      check("t4_hold_gnt", 32'(b_gnt), 32'd0);
    end
    @(posedge g_clk); #1;
    b_ack = 1;
    @(negedge g_clk);
    check("t4_nobypass", 32'(b_gnt), 32'd0);
    @(posedge g_clk); #1;
    b_ack = 0;
    @(negedge g_clk);
    check("t4_gnt_after_pop", 32'(b_gnt), 32'd1);
    check("t4_rd1_recv", 32'(b_recv), 32'd1);
    check("t4_rd1", b_rdata, 32'hB000_0001);
    @(posedge g_clk); #1;
    b_req = 0; b_ack = 1;
    @(negedge g_clk);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    check("t4_c_wait", 32'(b_recv), 32'd0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    check("t4_c_recv", 32'(b_recv), 32'd1);
    check("t4_rd2", b_rdata, 32'hB000_0002);
    @(posedge g_clk); #1;
    b_ack = 0;
    $display("xact t4 backpressure sequence done");

    // Pointer wrap: store/load pairs with random ack gaps on A
    for (int j = 0; j < 10; j++) pair_data[j] = $urandom;
    max_out = 0;
    pops = 0;
    a_ack = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          int w;
          w = 0;
          a_req = 1; a_wen = (k % 2 == 0); a_strb = 4'hF;
          a_addr = 32'h0002_0400 + 32'(4 * (k / 2));
          a_wdata = pair_data[k / 2];
          do begin @(negedge g_clk); w++; end while (!a_gnt && w < 50);
          if (!a_gnt) check("t5_gnt_timeout", 32'(a_gnt), 32'd1);
          exp_q.push_back(a_wen ? 32'd0 : pair_data[k / 2]);
          if (exp_q.size() > max_out) max_out = exp_q.size();
          @(posedge g_clk); #1;
        end
        a_req = 0;
      end
      begin
        int cyc;
        cyc = 0;
        while (pops < 20 && cyc < 1000) begin
          @(posedge g_clk); #1;
          a_ack = 1'($urandom_range(0, 1));
          cyc++;
          @(negedge g_clk);
          if (a_recv && a_ack) begin
            if (exp_q.size() == 0) check("t5_spurious", 32'(a_recv), 32'd0);
            else begin
              check("t5_rd", a_rdata, exp_q.pop_front());
              check("t5_err", 32'(a_error), 32'd0);
            end
            $display("xact t5 pop %0d rdata=%08h", pops, a_rdata);
            pops++;
          end
        end
      end
    join
    check("t5_pops", 32'(pops), 32'd20);
    check("t5_maxout_ok", 32'(max_out <= 2), 32'd1);
    @(posedge g_clk); #1;
    a_ack = 0;

    // Asynchronous reset with two responses pending
    a_req = 1; a_wen = 0; a_addr = 32'h0002_0000;
    @(negedge g_clk);
    @(posedge g_clk); #1;
    a_addr = 32'h0002_0010;
    @(negedge g_clk);
    @(posedge g_clk); #1;
    a_req = 0;
    @(negedge g_clk);
    check("t6_pend_recv", 32'(a_recv), 32'd1);
    check("t6_pend_gnt", 32'(a_gnt), 32'd0);
    check("t6_pend_rd", a_rdata, 32'h0123_4567);
    @(posedge g_clk); #3;
    g_resetn = 0;
    #1;
    check("t6_rst_recv", 32'(a_recv), 32'd0);
    check("t6_rst_gnt", 32'(a_gnt), 32'd0);
    check("t6_rst_rdata", a_rdata, 32'd0);
    check("t6_rst_err", 32'(a_error), 32'd0);
    a_req = 1; a_wen = 1; a_addr = 32'h0002_0000; a_wdata = 32'hBAD0_BAD0; a_strb = 4'hF;
    repeat (2) @(posedge g_clk);
    #1;
    a_req = 0;
    @(posedge g_clk); #3;
    g_resetn = 1;
    @(negedge g_clk);
    check("t6_post_gnt", 32'(a_gnt), 32'd1);
    check("t6_post_recv", 32'(a_recv), 32'd0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    check("t6_post_recv2", 32'(a_recv), 32'd0);
    @(posedge g_clk); #1;
    a_ack = 1;
    a_xact("t6_ld", 1'b0, 32'h0002_0000, 32'd0, 4'h0, 32'h0123_4567, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frv_dmem_responder.md
Name: frv_dmem_responder

Overview:
Data-memory responder for the core's dmem request/response interface: the target end of the port driven by the memory pipeline stage.
- Grants requests and applies stores to an internal word-addressed SRAM.
- Returns read data or an error through an in-order response queue with a configurable response latency.
- Used as the tightly-coupled data RAM in integration and as the reference slave in core-level benches.

Parameters:
MEM_BASE, 32'h0002_0000, base address of the RAM window
MEM_MASK, 32'hFFFF_F000, address bits compared against MEM_BASE
MEM_WORDS, 1024, number of 32-bit words (power of two, ≤ window size)
LATENCY, 1, cycles from grant to earliest dmem_recv (1..7)
QDEPTH, 2, maximum outstanding accepted requests (2 or 4)

Ports:
g_clk  in  1  global clock
g_resetn  in  1  asynchronous active-low reset
dmem_req  in  1  request valid
dmem_wen  in  1  1 = store, 0 = load
dmem_strb  in  4  store byte strobes
dmem_wdata  in  32  store data
dmem_addr  in  32  byte address
dmem_gnt  out  1  request accepted this cycle
dmem_recv  out  1  response valid
dmem_ack  in  1  initiator consumes response
dmem_error  out  1  response carries bus error
dmem_rdata  out  32  load data (0 for stores and errors)

Behaviour:
- Reset is asynchronous and active-low on g_resetn. While low:
  - dmem_gnt=0, dmem_recv=0, dmem_error=0, dmem_rdata=0.
  - Queue count cleared and all latency counters cleared.
  - SRAM contents are not reset.
- Reset asserted mid-transaction discards all outstanding responses; no partial store is committed after reset falls.
- Grant: dmem_gnt = (count < QDEPTH), combinational from registered count only. A pop in the same cycle does not raise gnt (no bypass).
- Accept = dmem_req && dmem_gnt.
  - The initiator holds req/addr/wdata/strb/wen stable until granted; the responder never latches an ungranted request.
- Address check: hit = (dmem_addr & MEM_MASK) == MEM_BASE. Word index = dmem_addr[log2(MEM_WORDS)+1:2]. Addresses in the window beyond MEM_WORDS alias via the index.
  - Miss → entry error=1. No SRAM write. rdata=0.
- Store on accept with hit: for each lane i with dmem_strb[i]=1, write byte i at the indexed word in that cycle. Entry rdata=0, error=0.
- Load on accept with hit: read the indexed word at accept; entry rdata = that word. A load accepted the cycle after a store to the same word returns the stored data.
- Queue: circular FIFO of QDEPTH entries {rdata, error, age}.
  - Pointers wrap modulo QDEPTH.
  - Push on accept with age=0. Every valid entry's age saturates-increments each cycle.
- Response: dmem_recv = (count != 0) && head.age >= LATENCY-1. Consequence: with LATENCY=1, recv is asserted the cycle after grant.
  - dmem_rdata and dmem_error show the head entry when recv=1, 0 otherwise.
- Pop = dmem_recv && dmem_ack. Responses are strictly in grant order.
- Once asserted, recv stays high with stable rdata/error until ack.
- dmem_ack without dmem_recv is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==QDEPTH): gnt=0 until the cycle after a pop.

Test Plan:
1. LATENCY=1: store addr 0x0002_0010, wdata 0xDEADBEEF, strb 4'hF, ack held high → gnt same cycle, recv next cycle with error=0, rdata=0. Then load 0x0002_0010 → recv 1 cycle after grant, rdata=0xDEADBEEF.
2. Byte strobes: word preset to 0x11223344; store wdata 0xAABBCCDD, strb 4'b0101; then load → rdata=0x11BB33DD.
3. Out-of-window load from 0x0000_1000 → recv with error=1, rdata=0. A load of 0x0002_0000 before and after returns the same value, proving no corruption.
4. Backpressure, QDEPTH=2, LATENCY=3, ack=0: three back-to-back loads → first two granted, gnt=0 on the third. Recv rises 3 cycles after first grant and holds stable. Ack one cycle → gnt=1 the following cycle. Responses return in order.
5. Pointer wrap: 10 alternating store/load pairs to distinct words with random ack gaps → every load returns its paired store data and count never exceeds QDEPTH.
6. Drop g_resetn asynchronously (mid-clock) with 2 responses pending → recv, error, rdata and gnt go to 0 immediately. After release gnt=1 and no stale recv appears.
